// File: rtl/aes_block_serializer.sv
// -----------------------------------------------------------------------------
// aes_block_serializer
//
// Purpose: accepts completed 128-bit AES blocks (one-cycle strobe from the AES
// core) into a two-deep block FIFO and streams the head block out one byte at
// a time over a valid/ready handshake. A block arriving while both slots are
// full is dropped with a one-cycle overflow pulse, unless the head block is
// handing over its final byte in that same cycle.
//
// Parameters:
//   MSB_FIRST   1: in[127:120] is emitted first; 0: in[7:0] is emitted first.
//
// Optional feature (macro AES_SER_DROP_CNT_EN):
//   adds output drop_count[7:0], a saturating count of dropped blocks.
//
// Ports:
//   clk         input   single clock
//   rst         input   synchronous active-high reset
//   inclk       input   one-cycle strobe qualifying in
//   in[127:0]   input   completed AES block
//   out_byte    output  current byte of the head block (0 when not valid)
//   out_valid   output  out_byte is valid
//   out_ready   input   downstream accepts out_byte
//   out_last    output  out_byte is byte 15 of its block
//   overflow    output  one-cycle pulse after an incoming block is dropped
//   busy        output  at least one block is buffered
//   drop_count  output  (AES_SER_DROP_CNT_EN only) saturating drop counter
// -----------------------------------------------------------------------------
module aes_block_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inclk,
  input  logic [127:0] in,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         overflow,
  output logic         busy
`ifdef AES_SER_DROP_CNT_EN
  ,
  output logic [7:0]   drop_count
`endif
);

  logic [127:0] mem_q [2];
  logic         wrPtr_q, wrPtr_d;
  logic         rdPtr_q, rdPtr_d;
  logic [1:0]   count_q, count_d;
  logic [3:0]   idx_q, idx_d;
  logic         valid_q;
  logic         overflow_q;

  logic         transfer;
  logic         popping;
  logic         pushing;
  logic         dropping;
  logic [3:0]   byteSel;
  logic [127:0] headBlock;

  // Handshake and FIFO bookkeeping. A full FIFO may still accept a block when
  // the head is popped in the same cycle: the freed slot is the one the write
  // pointer already points at, so the write lands there safely.
  always_comb begin
    transfer = valid_q && out_ready;
    popping  = transfer && (idx_q == 4'd15);
    pushing  = inclk && ((count_q != 2'd2) || popping);
    dropping = inclk && !pushing;
    count_d  = count_q + {1'b0, pushing} - {1'b0, popping};
    idx_d    = transfer ? idx_q + 4'd1 : idx_q;
    wrPtr_d  = pushing ? ~wrPtr_q : wrPtr_q;
    rdPtr_d  = popping ? ~rdPtr_q : rdPtr_q;
  end

  // State registers; reset wins over a simultaneous strobe, so that block is
  // discarded without an overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= 1'b0;
      rdPtr_q    <= 1'b0;
      count_q    <= 2'd0;
      idx_q      <= 4'd0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (pushing) begin
        mem_q[wrPtr_q] <= in;
      end
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      valid_q    <= (count_d != 2'd0);
      overflow_q <= dropping;
    end
  end

`ifdef AES_SER_DROP_CNT_EN
  logic [7:0] dropCnt_q, dropCnt_d;

  // Saturating count of dropped blocks.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (dropping && (dropCnt_q != 8'hFF)) begin
      dropCnt_d = dropCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dropCnt_q <= 8'd0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_count = dropCnt_q;
`endif

  // Byte select: idx counts bytes in emission order, mapped onto the block's
  // byte lanes according to MSB_FIRST.
  always_comb begin
    headBlock = mem_q[rdPtr_q];
    byteSel   = MSB_FIRST ? (4'd15 - idx_q) : idx_q;
    out_byte  = 8'd0;
    if (valid_q) begin
      out_byte = headBlock[{byteSel, 3'b000} +: 8];
    end
  end

  assign out_valid = valid_q;
  assign out_last  = valid_q && (idx_q == 4'd15);
  assign overflow  = overflow_q;
  assign busy      = valid_q;

endmodule

// File: tb/tb_aes_block_serializer.sv
// -----------------------------------------------------------------------------
// tb_aes_block_serializer
//
// Drives two serializers (MSB_FIRST=1 and MSB_FIRST=0) with identical stimulus.
// A reference model tracks how many bytes are buffered and, for every accepted
// block, queues the bytes each instance should emit. A monitor on the falling
// edge compares every DUT output against the model.
// -----------------------------------------------------------------------------
module tb_aes_block_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inclk = 1'b0;
  logic [127:0] inData = '0;
  logic         outReady = 1'b0;

  logic [7:0]   byteM, byteL;
  logic         validM, validL, lastM, lastL, ovfM, ovfL, busyM, busyL;
`ifdef AES_SER_DROP_CNT_EN
  logic [7:0]   dropM, dropL;
`endif

  int           vectors = 0;
  int           miscompares = 0;

  int           pendBytes = 0;
  logic         expOvf = 1'b0;
  int           expDrop = 0;
  bit           started = 1'b0;
  logic [8:0]   expM[$];
  logic [8:0]   expL[$];

  always #5 clk = ~clk;

  aes_block_serializer #(.MSB_FIRST(1'b1)) dutM (
    .clk(clk), .rst(rst), .inclk(inclk), .in(inData),
    .out_byte(byteM), .out_valid(validM), .out_ready(outReady),
    .out_last(lastM), .overflow(ovfM), .busy(busyM)
`ifdef AES_SER_DROP_CNT_EN
    , .drop_count(dropM)
`endif
  );

  aes_block_serializer #(.MSB_FIRST(1'b0)) dutL (
    .clk(clk), .rst(rst), .inclk(inclk), .in(inData),
    .out_byte(byteL), .out_valid(validL), .out_ready(outReady),
    .out_last(lastL), .overflow(ovfL), .busy(busyL)
`ifdef AES_SER_DROP_CNT_EN
    , .drop_count(dropL)
`endif
  );

  // One comparison: bumps the vector count, reports and counts a miscompare.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on buffered byte count. Occupancy is the number of
  // blocks with bytes still pending; a block is accepted if fewer than two are
  // buffered or the last byte of the head goes out this very cycle.
  initial begin
    bit xfer, fin, acc;
    int occ;
    forever begin
      @(posedge clk);
      if (rst) begin
        pendBytes = 0;
        expM.delete();
        expL.delete();
        expOvf  = 1'b0;
        expDrop = 0;
        started = 1'b1;
      end else begin
        xfer   = (pendBytes > 0) && outReady;
        fin    = xfer && ((pendBytes % 16) == 1);
        occ    = (pendBytes + 15) / 16;
        acc    = inclk && ((occ < 2) || fin);
        expOvf = inclk && !acc;
        if (expOvf && expDrop < 255) expDrop++;
        if (xfer) pendBytes--;
        if (acc) begin
          pendBytes += 16;
          for (int k = 0; k < 16; k++) begin
            expM.push_back({k == 15, inData[(15 - k) * 8 +: 8]});
            expL.push_back({k == 15, inData[k * 8 +: 8]});
          end
        end
      end
    end
  end

  // Monitor: compares outputs of both instances on the falling edge and pops
  // the expected byte whenever a transfer is about to happen.
  initial begin
    logic [8:0] front;
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("validM", validM, pendBytes > 0);
        checkOutput("validL", validL, pendBytes > 0);
        checkOutput("busyM", busyM, pendBytes > 0);
        checkOutput("busyL", busyL, pendBytes > 0);
        checkOutput("overflowM", ovfM, expOvf);
        checkOutput("overflowL", ovfL, expOvf);
`ifdef AES_SER_DROP_CNT_EN
        checkOutput("dropCountM", dropM, expDrop);
        checkOutput("dropCountL", dropL, expDrop);
`endif
        if (validM) begin
          if (expM.size() == 0) begin
            checkOutput("unexpectedByteM", 1, 0);
          end else begin
            front = expM[0];
            checkOutput("byteM", byteM, front[7:0]);
            checkOutput("lastM", lastM, front[8]);
            if (outReady) void'(expM.pop_front());
          end
        end else begin
          checkOutput("idleByteM", byteM, 0);
          checkOutput("idleLastM", lastM, 0);
        end
        if (validL) begin
          if (expL.size() == 0) begin
            checkOutput("unexpectedByteL", 1, 0);
          end else begin
            front = expL[0];
            checkOutput("byteL", byteL, front[7:0]);
            checkOutput("lastL", lastL, front[8]);
            if (outReady) void'(expL.pop_front());
          end
        end else begin
          checkOutput("idleByteL", byteL, 0);
          checkOutput("idleLastL", lastL, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe of a block, then junk on in to show it is ignored.
  task automatic applyStimulus(input logic [127:0] blk);
    inData = blk;
    inclk  = 1'b1;
    tick(1);
    inclk  = 1'b0;
    inData = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [127:0] seqBlk;
    int waited;
    seqBlk = 128'h000102030405060708090A0B0C0D0E0F;

    tick(3);
    rst = 1'b0;
    tick(1);

    // Single block, always ready.
    outReady = 1'b1;
    applyStimulus(seqBlk);
    tick(20);

    // Stall for 5 cycles while byte 3 is presented.
    applyStimulus(seqBlk);
    tick(3);
    outReady = 1'b0;
    tick(5);
    outReady = 1'b1;
    tick(20);

    // Three back-to-back strobes with downstream stalled: third is dropped.
    outReady = 1'b0;
    applyStimulus({4{$urandom}});
    applyStimulus({4{$urandom}});
    applyStimulus({4{$urandom}});
    tick(3);
    outReady = 1'b1;
    tick(40);

    // Full FIFO, third strobe lands on the head block's final transfer.
    outReady = 1'b0;
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    outReady = 1'b1;
    waited = 0;
    while (!lastM && waited < 40) begin
      tick(1);
      waited++;
    end
    if (!lastM) checkOutput("lastTimeout", 0, 1);
    applyStimulus({$urandom, $urandom, $urandom, $urandom});
    tick(60);

    // Reset while idx is 7, then a fresh block.
    applyStimulus(seqBlk);
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    applyStimulus(seqBlk);
    tick(20);

    // Reset colliding with a strobe.
    rst   = 1'b1;
    inclk = 1'b1;
    tick(1);
    rst   = 1'b0;
    inclk = 1'b0;
    tick(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      inData   = {$urandom, $urandom, $urandom, $urandom};
      inclk    = ($urandom_range(0, 9) < 2);
      outReady = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    inclk    = 1'b0;
    rst      = 1'b0;
    outReady = 1'b1;
    tick(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
